// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: packet sequencer (SYNC, LEN, payload, XOR checksum) feeding a payload FIFO
// Inputs : sys_clk, rst (sync, active-high), rx_valid/rx_data/rx_frame_err from uart_rx,
//          pl_ready from the payload consumer
// Outputs: pl_valid/pl_data/pl_last FIFO head, pkt_done/pkt_err pulses, err_code (held), busy
// Optional inter-byte timeout enabled by defining UART_RX_PKT_TIMEOUT_EN
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int MAX_LEN = 16,
    parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PKT_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_frame_err,
    output logic       pl_valid,
    output logic [7:0] pl_data,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [2:0] err_code,
    output logic       busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, xor_q, xor_d;
    logic [8:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [OW-1:0] occ_q;
    logic [2:0] code_q, code_d;
    logic done_q, done_d, err_q, err_d, busy_q;
    logic push, pop, full, tmo_hit;
    assign pl_valid = occ_q != '0;
    assign pop = pl_valid & pl_ready;
    assign full = occ_q == OW'(FIFO_DEPTH);
    // head is forced to zero when empty so stale entries never leak out after reset
    assign {pl_last, pl_data} = pl_valid ? mem_q[rd_q] : 9'd0;
    assign pkt_done = done_q;
    assign pkt_err = err_q;
    assign err_code = code_q;
    assign busy = busy_q;
`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    assign tmo_hit = (state_q != HUNT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge sys_clk) begin
        tmo_q <= (rst || rx_valid || state_q == HUNT || tmo_hit) ? '0 : tmo_q + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        xor_d = xor_q;
        code_d = code_q;
        push = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
        if (rx_valid && state_q != HUNT && rx_frame_err) begin
            err_d = 1'b1;
            code_d = 3'd2;
            state_d = HUNT;
        end else if (rx_valid) begin
            case (state_q)
                HUNT: state_d = (rx_data == SYNC_BYTE && !rx_frame_err) ? LEN : HUNT;
                LEN: begin
                    cnt_d = rx_data;
                    xor_d = rx_data;
                    if (rx_data == 8'd0) state_d = CSUM;
                    else if (rx_data > MAX_B) begin
                        err_d = 1'b1;
                        code_d = 3'd5;
                        state_d = HUNT;
                    end else state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    // a simultaneous pop frees the slot, so full only overflows without one
                    if (full && !pop) begin
                        err_d = 1'b1;
                        code_d = 3'd3;
                        state_d = HUNT;
                    end else begin
                        push = 1'b1;
                        xor_d = xor_q ^ rx_data;
                        cnt_d = cnt_q - 8'd1;
                        state_d = (cnt_q == 8'd1) ? CSUM : PAYLOAD;
                    end
                end
                CSUM: begin
                    done_d = rx_data == xor_q;
                    err_d = rx_data != xor_q;
                    code_d = (rx_data == xor_q) ? code_q : 3'd1;
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (tmo_hit) begin
            err_d = 1'b1;
            code_d = 3'd4;
            state_d = HUNT;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q <= '0;
            xor_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            occ_q <= '0;
            code_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            xor_q <= xor_d;
            wr_q <= push ? wr_q + PW'(1) : wr_q;
            rd_q <= pop ? rd_q + PW'(1) : rd_q;
            occ_q <= occ_q + OW'(push) - OW'(pop);
            code_q <= code_d;
            done_q <= done_d;
            err_q <= err_d;
            busy_q <= state_d != HUNT;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_q] <= {cnt_q == 8'd1, rx_data};
    end
endmodule
